// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback/issue bundle for the scoreboarded register file.
// The slave side is the register file; the master side is the pipeline.
interface regfile_scoreboard_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2
);
   logic                         init_done;
   logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]            rd_busy;
   logic                         wr_en;
   logic [ADDR_WIDTH-1:0]        wr_addr;
   logic [DATA_WIDTH-1:0]        wr_data;
   logic                         issue_en;
   logic [ADDR_WIDTH-1:0]        issue_addr;
   logic                         flush;

   modport slave (
      output init_done, rd_data, rd_busy,
      input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush
   );

   modport master (
      input  init_done, rd_data, rd_busy,
      output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register busy bits, write-through
// bypass and a post-reset clear sweep.
//
//   state | meaning
//   INIT  | clearing one entry per edge, all reads return 0, updates ignored
//   RUN   | normal operation: writeback, issue, flush, bypassed reads
module regfile_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2,
   parameter int ZERO_REG   = 1
) (
   input logic                clk,
   input logic                reset,
   regfile_scoreboard_if.slave bus
);
   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef enum logic {INIT, RUN} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   sweep_ptr;
   logic [DEPTH-1:0]        busy, busy_nxt;
   logic                    init_done_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    wr_ok, issue_ok, mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_data;
   logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;
   logic [NUM_RD-1:0]       rd_busy_c;

   assign wr_ok    = bus.wr_en    && !(ZERO_REG == 1 && bus.wr_addr == '0);
   assign issue_ok = bus.issue_en && !(ZERO_REG == 1 && bus.issue_addr == '0);

   always_ff @(posedge clk) begin
      if (!reset) state <= INIT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      mem_addr  = bus.wr_addr;
      mem_data  = bus.wr_data;
      busy_nxt  = busy;
      case (state)
         INIT: begin
            mem_we   = 1'b1;
            mem_addr = sweep_ptr;
            mem_data = '0;
            if (sweep_ptr == '1) state_nxt = RUN;
         end
         RUN: begin
            mem_we = wr_ok;
            if (wr_ok) busy_nxt[bus.wr_addr] = 1'b0;
            // issue after the writeback clear: a new producer keeps the bit set
            if (bus.flush)     busy_nxt = '0;
            else if (issue_ok) busy_nxt[bus.issue_addr] = 1'b1;
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset && mem_we) mem[mem_addr] <= mem_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sweep_ptr   <= '0;
         busy        <= '0;
         init_done_q <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (state == INIT) begin
            sweep_ptr <= sweep_ptr + 1'b1;
            if (sweep_ptr == '1) init_done_q <= 1'b1;
         end
      end
   end

   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         logic [ADDR_WIDTH-1:0] a;
         a = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
         if (state == INIT || (ZERO_REG == 1 && a == '0)) begin
            rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            rd_busy_c[k] = 1'b0;
         end else if (bus.wr_en && bus.wr_addr == a) begin
            rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
            rd_busy_c[k] = 1'b0;
         end else begin
            rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = mem[a];
            rd_busy_c[k] = busy[a];
         end
      end
   end

   assign bus.rd_data   = rd_data_c;
   assign bus.rd_busy   = rd_busy_c;
   assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a default instance and a ZERO_REG=0, NUM_RD=4
// instance share stimulus and are checked against an array model every cycle.
module tb_regfile_scoreboard;
   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en, issue_en, flush;
   logic [4:0]  wr_addr, issue_addr;
   logic [31:0] wr_data;
   logic [4:0]  ra [4];
   bit          chk_on = 1'b0;
   int          total = 0;
   int          bad = 0;

   // model: index 0 = default instance, index 1 = ZERO_REG=0 / NUM_RD=4
   logic [31:0] mmem  [2][32];
   bit          mbusy [2][32];
   bit          mrun  [2];
   int          msweep[2];

   always #5 clk = ~clk;

   regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) ifa ();
   regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(4)) ifb ();

   assign ifa.rd_addr    = {ra[1], ra[0]};
   assign ifb.rd_addr    = {ra[3], ra[2], ra[1], ra[0]};
   assign ifa.wr_en      = wr_en;
   assign ifb.wr_en      = wr_en;
   assign ifa.wr_addr    = wr_addr;
   assign ifb.wr_addr    = wr_addr;
   assign ifa.wr_data    = wr_data;
   assign ifb.wr_data    = wr_data;
   assign ifa.issue_en   = issue_en;
   assign ifb.issue_en   = issue_en;
   assign ifa.issue_addr = issue_addr;
   assign ifb.issue_addr = issue_addr;
   assign ifa.flush      = flush;
   assign ifb.flush      = flush;

   regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa.slave));
   regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(4), .ZERO_REG(0)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb.slave));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         bit zr;
         zr = (d == 0);
         if (!reset) begin
            mrun[d] = 1'b0;
            msweep[d] = 0;
            for (int i = 0; i < 32; i++) mbusy[d][i] = 1'b0;
         end else if (!mrun[d]) begin
            mmem[d][msweep[d]] = '0;
            msweep[d]++;
            if (msweep[d] == 32) mrun[d] = 1'b1;
         end else begin
            if (wr_en && !(zr && wr_addr == 0)) begin
               mmem[d][wr_addr] = wr_data;
               mbusy[d][wr_addr] = 1'b0;
            end
            if (flush)
               for (int i = 0; i < 32; i++) mbusy[d][i] = 1'b0;
            else if (issue_en && !(zr && issue_addr == 0))
               mbusy[d][issue_addr] = 1'b1;
         end
      end
   end

   function automatic logic [32:0] mexp(input int d, input logic [4:0] a);
      if (!mrun[d])                  return '0;
      if (d == 0 && a == 0)          return '0;
      if (wr_en && wr_addr == a)     return {1'b0, wr_data};
      return {mbusy[d][a], mmem[d][a]};
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         chk("a.init_done", 64'(ifa.init_done), 64'(mrun[0]));
         chk("b.init_done", 64'(ifb.init_done), 64'(mrun[1]));
         for (int k = 0; k < 2; k++)
            chk($sformatf("a.port%0d", k), 64'({ifa.rd_busy[k], ifa.rd_data[k*32 +: 32]}),
                64'(mexp(0, ra[k])));
         for (int k = 0; k < 4; k++)
            chk($sformatf("b.port%0d", k), 64'({ifb.rd_busy[k], ifb.rd_data[k*32 +: 32]}),
                64'(mexp(1, ra[k])));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 0; issue_en = 0; flush = 0;
   endtask

   initial begin
      reset = 0; idle(); wr_addr = 0; wr_data = 0; issue_addr = 0;
      for (int k = 0; k < 4; k++) ra[k] = 0;
      step();
      chk_on = 1'b1;
      step();
      reset = 1;
      // writes during the sweep must be dropped
      wr_en = 1; wr_addr = 3; wr_data = 32'h3333_3333; ra[0] = 3;
      issue_en = 1; issue_addr = 4; ra[1] = 4;
      repeat (31) step();
      chk("init_done_edge31", 64'(ifa.init_done), 64'd0);
      step();
      chk("init_done_edge32", 64'(ifa.init_done), 64'd1);
      idle();
      #1;
      chk("sweep_reg3_data", 64'(ifa.rd_data[31:0]), 64'd0);
      chk("sweep_reg4_busy", 64'(ifa.rd_busy[1]), 64'd0);

      wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; ra[0] = 5;
      #1 chk("bypass_reg5", 64'(ifa.rd_data[31:0]), 64'hDEADBEEF);
      step(); idle();
      #1 chk("stored_reg5", 64'(ifa.rd_data[31:0]), 64'hDEADBEEF);

      issue_en = 1; issue_addr = 7;
      step(); idle(); ra[1] = 7;
      #1 chk("issued_reg7_busy", 64'(ifa.rd_busy[1]), 64'd1);
      wr_en = 1; wr_addr = 7; wr_data = 32'h12;
      #1 chk("wb_reg7_busy", 64'(ifa.rd_busy[1]), 64'd0);
      chk("wb_reg7_data", 64'(ifa.rd_data[63:32]), 64'h12);
      step(); idle();
      #1 chk("after_wb_reg7_busy", 64'(ifa.rd_busy[1]), 64'd0);

      issue_en = 1; issue_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h55;
      step(); idle(); ra[0] = 9;
      #1 chk("same_edge_reg9_data", 64'(ifa.rd_data[31:0]), 64'h55);
      chk("same_edge_reg9_busy", 64'(ifa.rd_busy[0]), 64'd1);
      flush = 1; issue_en = 1; issue_addr = 10; ra[1] = 10;
      step(); idle();
      #1 chk("flush_reg9_busy", 64'(ifa.rd_busy[0]), 64'd0);
      chk("flush_reg10_busy", 64'(ifa.rd_busy[1]), 64'd0);

      wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; issue_en = 1; issue_addr = 0;
      step(); idle();
      for (int k = 0; k < 4; k++) ra[k] = 0;
      #1 chk("zr_reg0", 64'({ifa.rd_busy[0], ifa.rd_data[31:0]}), 64'd0);
      for (int k = 0; k < 4; k++)
         chk($sformatf("nzr_reg0_port%0d", k), 64'({ifb.rd_busy[k], ifb.rd_data[k*32 +: 32]}),
             {31'd0, 1'b1, 32'hFFFFFFFF});

      wr_en = 1; wr_addr = 2; wr_data = 32'hA5; issue_en = 1; issue_addr = 11;
      step(); idle(); ra[0] = 2; ra[1] = 11;
      #1 chk("reg2_before_reset", 64'(ifa.rd_data[31:0]), 64'hA5);
      reset = 0;
      step(); reset = 1;
      #1 chk("mid_reset_init_done", 64'(ifa.init_done), 64'd0);
      repeat (32) step();
      chk("resweep_init_done", 64'(ifa.init_done), 64'd1);
      chk("resweep_reg2", 64'(ifa.rd_data[31:0]), 64'd0);
      chk("resweep_reg11_busy", 64'(ifa.rd_busy[1]), 64'd0);

      // a few mixed cycles under the model
      for (int i = 0; i < 8; i++) begin
         wr_en = i[0]; wr_addr = 5'(i * 3); wr_data = 32'h1000 + 32'(i);
         issue_en = i[1]; issue_addr = 5'(i * 5); flush = (i == 6);
         ra[0] = 5'(i * 3); ra[1] = 5'(i * 5); ra[2] = 5'(i); ra[3] = 0;
         step();
      end
      idle();
      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
